writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-write entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream result present.
REQ-005 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-006 SHALL have port in_id  input  4  destination register id.
REQ-007 SHALL have port in_value  input  8  result data.
REQ-008 SHALL have port write_id  output  4  register-block write select; 0 means no write.
REQ-009 SHALL have port write_value  output  8  register-block write data.
REQ-010 SHALL have port query1_id  input  4  decode read-port-1 id.
REQ-011 SHALL have port query2_id  input  4  decode read-port-2 id.
REQ-012 SHALL have port hit1  output  1  pending write exists for query1_id.
REQ-013 SHALL have port hit1_value  output  8  youngest pending value for query1_id.
REQ-014 SHALL have port hit2  output  1  pending write exists for query2_id.
REQ-015 SHALL have port hit2_value  output  8  youngest pending value for query2_id.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH {id,value} entries, with head pointer, tail pointer and count registers.
REQ-017 SHALL drive in_ready = (count < DEPTH) and not reset; when full, no same-cycle push-on-pop bypass.
REQ-018 SHALL treat in_valid and in_ready both high at a rising edge as an accept.
REQ-019 SHALL accept but discard, without storing, any accepted entry whose in_id is 0 (read-only r0) or 13-15 (unmapped).
REQ-020 SHALL, in each cycle where count > 0, pop the head entry and register it onto write_id/write_value for exactly one cycle.
REQ-021 SHALL register write_id = 0 and write_value = 0 in every cycle where count = 0 at the preceding edge.
REQ-022 SHALL have a latency of one cycle: an entry accepted into an empty queue at edge N appears on write_id/write_value from edge N+1 to edge N+2.
REQ-023 SHALL sustain one commit per cycle with simultaneous push and pop when not full; count is then unchanged.
REQ-024 SHALL preserve FIFO order; back-to-back entries to the same id are all committed, oldest first.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH with no lost or duplicated entries.
REQ-026 SHALL compute hitN/hitN_value combinationally, matching queryN_id against all valid FIFO entries plus the current write_id/write_value output stage.
REQ-027 SHALL select the youngest match: FIFO tail-most entry first, then the output stage.
REQ-028 SHALL drive hitN = 0 and hitN_value = 0 when queryN_id is 0, 13-15, or unmatched.
REQ-029 SHALL exclude the entry being presented on in_id in the same cycle from hit matching; it is visible from the next cycle.

Reset
REQ-030 SHALL, while reset is high at an edge, clear count, head and tail to 0, and drive write_id = 0, write_value = 0.
REQ-031 SHALL drive in_ready = 0 while reset is high and ignore in_valid during that cycle.
REQ-032 SHALL drive hit1 = hit2 = 0 in the cycle after reset.
REQ-033 SHALL flush any entries pending when reset is asserted mid-operation; no flushed entry is written.

Verification
REQ-034 Single write: push (id 3, 0x5A) into empty queue -> next cycle write_id = 3, write_value = 0x5A; following cycle write_id = 0.
REQ-035 Discard: push ids 0, 13, 15 -> all accepted (in_ready = 1), write_id stays 0, no hits.
REQ-036 Full/backpressure: hold write port busy via DEPTH+2 back-to-back pushes ids 1..6 with DEPTH = 4 -> every id committed once in order, in_ready never drops, throughput one per cycle.
REQ-037 Forwarding: queue holds (id 5, 0x11) then (id 5, 0x22), query1_id = 5 -> hit1 = 1, hit1_value = 0x22; query2_id = 6 -> hit2 = 0.
REQ-038 Wrap-around: 3 x DEPTH pushes, values 0x00..0x0B, with random in_valid gaps -> writes observed in order with no loss or duplication.
REQ-039 Reset mid-operation: 3 entries pending, assert reset one cycle -> write_id = 0 thereafter, no pending id written, in_ready = 1 after release.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback queue: buffers {id,value} results and commits one per cycle to the register block.
// Decode read ports are forwarded from pending entries and the commit stage, youngest first.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_id,
  input  logic [7:0] in_value,
  output logic [3:0] write_id,
  output logic [7:0] write_value,
  input  logic [3:0] query1_id,
  input  logic [3:0] query2_id,
  output logic       hit1,
  output logic [7:0] hit1_value,
  output logic       hit2,
  output logic [7:0] hit2_value
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    r_mem_id  [DEPTH];
  logic [7:0]    r_mem_val [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [3:0]    r_wr_id;
  logic [7:0]    r_wr_val;

  logic       w_accept;
  logic       w_mapped;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_qid  [2];
  logic       w_hit  [2];
  logic [7:0] w_hval [2];

  // r0 is read-only and ids 13-15 are unmapped: accepted, never stored
  assign in_ready = (r_count < CW'(DEPTH)) && !reset;
  assign w_accept = in_valid && in_ready;
  assign w_mapped = (in_id != 4'd0) && (in_id < 4'd13);
  assign w_push   = w_accept && w_mapped;
  assign w_pop    = (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_tail]  <= in_id;
      r_mem_val[r_tail] <= in_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_wr_id  <= '0;
      r_wr_val <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_wr_id  <= r_mem_id[r_head];
        r_wr_val <= r_mem_val[r_head];
        r_head   <= r_head + 1'b1;
      end else begin
        r_wr_id  <= '0;
        r_wr_val <= '0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign write_id    = r_wr_id;
  assign write_value = r_wr_val;

  assign w_qid[0] = query1_id;
  assign w_qid[1] = query2_id;

  // Commit stage is oldest; FIFO walked head to tail so later matches win
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_hit[p]  = 1'b0;
      w_hval[p] = '0;
      if ((w_qid[p] != 4'd0) && (w_qid[p] < 4'd13)) begin
        if (r_wr_id == w_qid[p]) begin
          w_hit[p]  = 1'b1;
          w_hval[p] = r_wr_val;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if ((CW'(i) < r_count) && (r_mem_id[r_head + PW'(i)] == w_qid[p])) begin
            w_hit[p]  = 1'b1;
            w_hval[p] = r_mem_val[r_head + PW'(i)];
          end
        end
      end
    end
  end

  assign hit1       = w_hit[0];
  assign hit1_value = w_hval[0];
  assign hit2       = w_hit[1];
  assign hit2_value = w_hval[1];

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed pushes feed a scoreboard of expected commits
// (id, value, cycle); a negedge monitor checks every write port cycle against it.
module tb_writeback_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_id;
  logic [7:0] in_value;
  logic [3:0] write_id;
  logic [7:0] write_value;
  logic [3:0] query1_id;
  logic [3:0] query2_id;
  logic       hit1;
  logic [7:0] hit1_value;
  logic       hit2;
  logic [7:0] hit2_value;

  writeback_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_id       (in_id),
    .in_value    (in_value),
    .write_id    (write_id),
    .write_value (write_value),
    .query1_id   (query1_id),
    .query2_id   (query2_id),
    .hit1        (hit1),
    .hit1_value  (hit1_value),
    .hit2        (hit2),
    .hit2_value  (hit2_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every non-zero write must be the next expected entry, on its expected cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (write_id !== 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_id", {28'd0, write_id}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_id", {28'd0, write_id}, {28'd0, e.id});
          chk("commit_value", {24'd0, write_value}, {24'd0, e.val});
          chk("commit_cycle", cyc, e.cyc);
        end
      end else if (write_value !== 8'd0) begin
        chk("idle_write_value", {24'd0, write_value}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one entry for one edge; the queue never fills at one push per cycle
  task automatic drive(input logic [3:0] id, input logic [7:0] val);
    exp_t e;
    in_valid = 1'b1;
    in_id    = id;
    in_value = val;
    #0;
    chk("in_ready_on_push", {31'd0, in_ready}, 32'd1);
    if (id != 4'd0 && id < 4'd13) begin
      e.id  = id;
      e.val = val;
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_id     = 4'd0;
    in_value  = 8'd0;
    query1_id = 4'd0;
    query2_id = 4'd0;
    repeat (2) tick();
    chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset_write_id", {28'd0, write_id}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    query1_id = 4'd3;
    query2_id = 4'd5;
    #1;
    chk("reset_hit1", {31'd0, hit1}, 32'd0);
    chk("reset_hit2", {31'd0, hit2}, 32'd0);
    mon_en = 1'b1;

    // Single write with one-cycle latency
    drive(4'd3, 8'h5A);
    chk("single_not_yet", {28'd0, write_id}, 32'd0);
    tick();
    chk("single_id", {28'd0, write_id}, 32'd3);
    chk("single_value", {24'd0, write_value}, 32'h5A);
    tick();
    chk("single_done", {28'd0, write_id}, 32'd0);

    // Discarded ids: accepted, never stored or forwarded
    query1_id = 4'd13;
    query2_id = 4'd0;
    drive(4'd0, 8'h11);
    drive(4'd13, 8'h22);
    drive(4'd15, 8'h33);
    chk("discard_hit1", {31'd0, hit1}, 32'd0);
    chk("discard_hit2", {31'd0, hit2}, 32'd0);
    idle(2);
    chk("discard_write_id", {28'd0, write_id}, 32'd0);

    // Back-to-back ids 1..6: one commit per cycle in order
    for (int i = 1; i <= 6; i++) drive(4'(i), 8'(8'hA0 + i));
    idle(3);

    // Forwarding: youngest pending value wins, presented entry excluded
    query1_id = 4'd5;
    query2_id = 4'd6;
    in_valid  = 1'b1;
    in_id     = 4'd5;
    #1;
    chk("fwd_presented_excluded", {31'd0, hit1}, 32'd0);
    drive(4'd5, 8'h11);
    in_valid = 1'b1;
    in_id    = 4'd5;
    in_value = 8'h22;
    #1;
    chk("fwd_first_hit", {31'd0, hit1}, 32'd1);
    chk("fwd_first_value", {24'd0, hit1_value}, 32'h11);
    drive(4'd5, 8'h22);
    chk("fwd_young_hit", {31'd0, hit1}, 32'd1);
    chk("fwd_young_value", {24'd0, hit1_value}, 32'h22);
    chk("fwd_hit2_miss", {31'd0, hit2}, 32'd0);
    chk("fwd_hit2_value", {24'd0, hit2_value}, 32'd0);
    tick();
    chk("fwd_stage_hit", {31'd0, hit1}, 32'd1);
    chk("fwd_stage_value", {24'd0, hit1_value}, 32'h22);
    tick();
    chk("fwd_drained", {31'd0, hit1}, 32'd0);

    // Wrap-around with random gaps
    for (int i = 0; i < 12; i++) begin
      drive(4'((i % 6) + 1), 8'(i));
      idle($urandom_range(0, 2));
    end
    idle(3);

    // Reset mid-operation: only entries already on the write port survive
    drive(4'd7, 8'h71);
    drive(4'd8, 8'h82);
    drive(4'd9, 8'h93);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midreset_write_id", {28'd0, write_id}, 32'd0);
    chk("midreset_in_ready_after", {31'd0, in_ready}, 32'd1);
    query1_id = 4'd9;
    #1;
    chk("midreset_hit1", {31'd0, hit1}, 32'd0);
    idle(4);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
